// File: rtl/counter_monitor.sv
// Monitor for an up/down/load counter under test. Predicts the counter's next
// (Q, RCO, LOAD) from its observed state and inputs, compares one edge later,
// and reports mismatches through a registered pulse, a sticky flag and
// saturating counters. Optionally halts on the first mismatch.
module counter_monitor #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             ENABLE,
   input  logic [1:0]       MODO,
   input  logic [WIDTH-1:0] D,
   input  logic [WIDTH-1:0] Q,
   input  logic             RCO,
   input  logic             LOAD,
   input  logic             STOP_ON_ERR,
   output logic             ERROR,
   output logic             ERR_FLAG,
   output logic [7:0]       ERR_CNT,
   output logic [15:0]      CHK_CNT,
   output logic [WIDTH-1:0] EXP_Q,
   output logic             HALTED
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_CHECK = 2'd1;
   localparam logic [1:0] ST_HALT  = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] exp_q_q;
   logic             exp_rco_q;
   logic             exp_load_q;
   logic             error_q;
   logic             err_flag_q;
   logic [7:0]       err_cnt_q;
   logic [15:0]      chk_cnt_q;

   logic [WIDTH:0]   sum3;
   logic [WIDTH-1:0] pred_q;
   logic             pred_rco;
   logic             pred_load;
   logic             mismatch;
   logic             active;

   // Carry out of Q+3 is the wrap condition for the count-by-3 mode.
   assign sum3 = {1'b0, Q} + (WIDTH+1)'(3);

   // Reference model: next counter outputs from the observed Q, not from EXP_Q,
   // so one bad step yields exactly one mismatch.
   always_comb begin
      pred_q    = Q;
      pred_rco  = 1'b0;
      pred_load = 1'b0;
      if (ENABLE) begin
         case (MODO)
            2'b00: begin
               pred_q   = sum3[WIDTH-1:0];
               pred_rco = sum3[WIDTH];
            end
            2'b01: begin
               pred_q   = Q - WIDTH'(1);
               pred_rco = (Q == '0);
            end
            2'b10: begin
               pred_q   = Q + WIDTH'(1);
               pred_rco = (Q == '1);
            end
            default: begin
               pred_q    = D;
               pred_load = 1'b1;
            end
         endcase
      end
   end

   assign mismatch = (Q != exp_q_q) || (RCO != exp_rco_q) || (LOAD != exp_load_q);
   assign active   = (state_q != ST_HALT);

   // FSM next state: any checking edge leaves IDLE; a mismatch with stop enabled halts.
   always_comb begin
      state_d = state_q;
      if (active) begin
         state_d = (mismatch && STOP_ON_ERR) ? ST_HALT : ST_CHECK;
      end
   end

   // Comparison, counters and prediction update; everything frozen in HALT.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q    <= ST_IDLE;
         exp_q_q    <= '0;
         exp_rco_q  <= 1'b0;
         exp_load_q <= 1'b0;
         error_q    <= 1'b0;
         err_flag_q <= 1'b0;
         err_cnt_q  <= 8'd0;
         chk_cnt_q  <= 16'd0;
      end else begin
         state_q <= state_d;
         if (active) begin
            error_q <= mismatch;
            if (mismatch) begin
               err_flag_q <= 1'b1;
               if (err_cnt_q != 8'hFF) begin
                  err_cnt_q <= err_cnt_q + 8'd1;
               end
            end
            if (chk_cnt_q != 16'hFFFF) begin
               chk_cnt_q <= chk_cnt_q + 16'd1;
            end
            exp_q_q    <= pred_q;
            exp_rco_q  <= pred_rco;
            exp_load_q <= pred_load;
         end else begin
            error_q <= 1'b0;
         end
      end
   end

   assign ERROR    = error_q;
   assign ERR_FLAG = err_flag_q;
   assign ERR_CNT  = err_cnt_q;
   assign CHK_CNT  = chk_cnt_q;
   assign EXP_Q    = exp_q_q;
   assign HALTED   = (state_q == ST_HALT);

endmodule

// File: tb/tb_counter_monitor.sv
// Directed bench for counter_monitor (WIDTH=4). Each step drives one counter
// observation, queues the ERROR value it must produce, and checks it one edge later.
module tb_counter_monitor;

   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic       ENABLE = 1'b0;
   logic [1:0] MODO = 2'b00;
   logic [3:0] D = 4'd0;
   logic [3:0] Q = 4'd0;
   logic       RCO = 1'b0;
   logic       LOAD = 1'b0;
   logic       STOP_ON_ERR = 1'b0;
   logic       ERROR;
   logic       ERR_FLAG;
   logic [7:0] ERR_CNT;
   logic [15:0] CHK_CNT;
   logic [3:0] EXP_Q;
   logic       HALTED;

   int n_checks = 0;
   int n_pass = 0;
   logic sb[$];

   counter_monitor #(.WIDTH(4)) dut (
      .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .MODO(MODO), .D(D), .Q(Q),
      .RCO(RCO), .LOAD(LOAD), .STOP_ON_ERR(STOP_ON_ERR), .ERROR(ERROR),
      .ERR_FLAG(ERR_FLAG), .ERR_CNT(ERR_CNT), .CHK_CNT(CHK_CNT), .EXP_Q(EXP_Q),
      .HALTED(HALTED)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Drive one observation, then compare the registered ERROR after the edge.
   task automatic step(input logic [3:0] q, input logic r, input logic l, input logic en,
                       input logic [1:0] m, input logic [3:0] d, input logic exp_err);
      logic e;
      Q = q; RCO = r; LOAD = l; ENABLE = en; MODO = m; D = d;
      sb.push_back(exp_err);
      @(posedge CLK);
      #1;
      e = sb.pop_front();
      check("error", {31'd0, ERROR}, {31'd0, e});
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_error"}, {31'd0, ERROR}, 32'd0);
      check({tag, "_flag"}, {31'd0, ERR_FLAG}, 32'd0);
      check({tag, "_errcnt"}, {24'd0, ERR_CNT}, 32'd0);
      check({tag, "_chkcnt"}, {16'd0, CHK_CNT}, 32'd0);
      check({tag, "_expq"}, {28'd0, EXP_Q}, 32'd0);
      check({tag, "_halted"}, {31'd0, HALTED}, 32'd0);
   endtask

   task automatic do_reset();
      RESET = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      RESET = 1'b0;
   endtask

   initial begin
      #1;
      check_reset_vals("por");
      repeat (2) @(posedge CLK);
      #1;
      RESET = 1'b0;

      // Clean up-count 0..15,0 with carry on wrap.
      for (int i = 0; i < 16; i++) step(4'(i), 1'b0, 1'b0, 1'b1, 2'b10, 4'd0, 1'b0);
      step(4'd0, 1'b1, 1'b0, 1'b1, 2'b10, 4'd0, 1'b0);
      check("clean_chkcnt", {16'd0, CHK_CNT}, 32'd17);
      check("clean_errcnt", {24'd0, ERR_CNT}, 32'd0);
      check("clean_expq", {28'd0, EXP_Q}, 32'd1);

      // Load 14, count by 3 with missing carry, then a correct step.
      step(4'd1, 1'b0, 1'b0, 1'b1, 2'b11, 4'd14, 1'b0);
      step(4'd14, 1'b0, 1'b1, 1'b1, 2'b00, 4'd0, 1'b0);
      step(4'd1, 1'b0, 1'b0, 1'b1, 2'b00, 4'd0, 1'b1);
      check("wrap_errcnt", {24'd0, ERR_CNT}, 32'd1);
      check("wrap_flag", {31'd0, ERR_FLAG}, 32'd1);
      step(4'd4, 1'b0, 1'b0, 1'b1, 2'b00, 4'd0, 1'b0);
      check("wrap_expq", {28'd0, EXP_Q}, 32'd7);

      // Parallel load of 9: correct, then wrong value.
      step(4'd7, 1'b0, 1'b0, 1'b1, 2'b11, 4'd9, 1'b0);
      step(4'd9, 1'b0, 1'b1, 1'b1, 2'b11, 4'd9, 1'b0);
      step(4'd8, 1'b0, 1'b1, 1'b1, 2'b11, 4'd9, 1'b1);
      check("load_errcnt", {24'd0, ERR_CNT}, 32'd2);

      // Hold with enable low, then an illegal change.
      step(4'd9, 1'b0, 1'b1, 1'b1, 2'b11, 4'd5, 1'b0);
      step(4'd5, 1'b0, 1'b1, 1'b0, 2'b00, 4'd0, 1'b0);
      step(4'd6, 1'b0, 1'b0, 1'b0, 2'b00, 4'd0, 1'b1);
      check("hold_errcnt", {24'd0, ERR_CNT}, 32'd3);

      // Underflow 0 -> 15 with carry.
      step(4'd6, 1'b0, 1'b0, 1'b1, 2'b11, 4'd0, 1'b0);
      step(4'd0, 1'b0, 1'b1, 1'b1, 2'b01, 4'd0, 1'b0);
      step(4'd15, 1'b1, 1'b0, 1'b1, 2'b01, 4'd0, 1'b0);
      check("under_errcnt", {24'd0, ERR_CNT}, 32'd3);
      check("under_expq", {28'd0, EXP_Q}, 32'd14);

      // All three fields wrong still counts once.
      step(4'd3, 1'b1, 1'b1, 1'b1, 2'b10, 4'd0, 1'b1);
      check("multi_errcnt", {24'd0, ERR_CNT}, 32'd4);
      check("multi_chkcnt", {16'd0, CHK_CNT}, 32'd31);

      // Asynchronous reset between edges.
      #2;
      RESET = 1'b1;
      #1;
      check_reset_vals("async");
      @(posedge CLK);
      #1;
      check("inreset_chkcnt", {16'd0, CHK_CNT}, 32'd0);
      RESET = 1'b0;

      // Halt on the mismatch at edge 3.
      STOP_ON_ERR = 1'b1;
      step(4'd0, 1'b0, 1'b0, 1'b1, 2'b10, 4'd0, 1'b0);
      step(4'd1, 1'b0, 1'b0, 1'b1, 2'b10, 4'd0, 1'b0);
      step(4'd5, 1'b0, 1'b0, 1'b1, 2'b10, 4'd0, 1'b1);
      check("halt_halted", {31'd0, HALTED}, 32'd1);
      check("halt_chkcnt", {16'd0, CHK_CNT}, 32'd3);
      check("halt_errcnt", {24'd0, ERR_CNT}, 32'd1);
      check("halt_expq", {28'd0, EXP_Q}, 32'd6);
      step(4'd9, 1'b1, 1'b1, 1'b1, 2'b10, 4'd0, 1'b0);
      step(4'd2, 1'b0, 1'b0, 1'b1, 2'b00, 4'd0, 1'b0);
      check("halted_chkcnt", {16'd0, CHK_CNT}, 32'd3);
      check("halted_errcnt", {24'd0, ERR_CNT}, 32'd1);
      check("halted_expq", {28'd0, EXP_Q}, 32'd6);
      check("halted_halted", {31'd0, HALTED}, 32'd1);

      // Reset releases HALT; first edge checks Q=0, so Q=7 mismatches.
      // 300 consecutive mismatches saturate ERR_CNT.
      STOP_ON_ERR = 1'b0;
      do_reset();
      check("rel_halted", {31'd0, HALTED}, 32'd0);
      for (int i = 0; i < 300; i++) step(4'd7, 1'b0, 1'b0, 1'b1, 2'b10, 4'd0, 1'b1);
      check("sat_errcnt", {24'd0, ERR_CNT}, 32'd255);
      check("sat_chkcnt", {16'd0, CHK_CNT}, 32'd300);
      check("sat_flag", {31'd0, ERR_FLAG}, 32'd1);
      check("sat_halted", {31'd0, HALTED}, 32'd0);

      // Stop enabled mid-run applies to the next mismatch.
      STOP_ON_ERR = 1'b1;
      step(4'd7, 1'b0, 1'b0, 1'b1, 2'b10, 4'd0, 1'b1);
      check("late_halted", {31'd0, HALTED}, 32'd1);
      check("late_chkcnt", {16'd0, CHK_CNT}, 32'd301);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
